addsub_ctl: RTL and testbench
=============================

ADDSUB_CTL -- requirements
Module: addsub_ctl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles to wait for mem_ack before aborting with err.
REQ-002 SHALL have port clk  in  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  in  1  single-cycle command strobe, sampled only in IDLE.
REQ-005 SHALL have port op  in  2  00 ADD, 01 SUB, 10 INC, 11 DEC.
REQ-006 SHALL have port fspec  in  6  MIX field F=8L+R for ADD/SUB.
REQ-007 SHALL have port imm  in  13  sign + 12-bit magnitude immediate for INC/DEC.
REQ-008 SHALL have port mem_req  out  1  memory read request, held until acknowledged.
REQ-009 SHALL have port mem_ack  in  1  memory data valid.
REQ-010 SHALL have port mem_data  in  31  MIX word: bit30 sign, bytes 1..5 at [29:24]..[5:0].
REQ-011 SHALL have port ra_in  in  31  current rA.
REQ-012 SHALL have port ra_out  out  31  new rA value.
REQ-013 SHALL have port ra_we  out  1  one-cycle rA write strobe.
REQ-014 SHALL have port ovf_set  out  1  one-cycle overflow-toggle set strobe.
REQ-015 SHALL have port busy  out  1  high in every state except IDLE.
REQ-016 SHALL have port done  out  1  one-cycle completion pulse.
REQ-017 SHALL have port err  out  1  one-cycle abort pulse.

Function
REQ-018 SHALL implement states IDLE, FETCH, EXEC, WRITE.
REQ-019 SHALL go IDLE->FETCH on start with ADD/SUB and a valid fspec, and SHALL assert mem_req from the next cycle.
REQ-020 SHALL, in FETCH, register mem_data on the cycle mem_ack=1, drop mem_req, and go to EXEC.
REQ-021 SHALL pulse err and return to IDLE, without ra_we, when TIMEOUT cycles elapse in FETCH without mem_ack.
REQ-022 SHALL treat fspec as invalid when L>R or R>5, and SHALL then pulse err the cycle after start and stay in IDLE.
REQ-023 SHALL extract the operand as bytes L'..R right-justified, where L'=max(L,1), with sign = mem sign if L=0 and + otherwise.
REQ-024 SHALL invert the operand sign for SUB and DEC.
REQ-025 SHALL, in EXEC, drive rA and the operand into the sign-magnitude adder and register the sum and carry.
REQ-026 SHALL, in WRITE, assert ra_we and done and return to IDLE.
REQ-027 SHALL assert ovf_set in WRITE when the magnitude carry is set; ra_out then holds the sum magnitude mod 2^30.
REQ-028 SHALL give a zero-magnitude result the sign of ra_in.
REQ-029 SHALL give ADD/SUB a latency of start→done = 3 + k cycles, where k is the number of cycles from the first mem_req to mem_ack (k>=1).
REQ-030 SHALL ignore start while busy=1.
REQ-031 SHALL keep ra_out stable outside WRITE; its value there is don't-care.

Reset
REQ-032 SHALL, while rst_n=0, force state IDLE and mem_req, ra_we, ovf_set, busy, done, err, ra_out and the timeout counter to 0.
REQ-033 SHALL abandon an in-flight command on reset mid-operation, with no ra_we issued; a mem_ack arriving after reset SHALL be ignored.

Configuration
REQ-034 SHALL, with ADDSUB_INC_EN defined, execute INC/DEC as IDLE->EXEC->WRITE with operand = imm zero-extended to 30 bits and no memory access (latency 3).
REQ-035 SHALL, without ADDSUB_INC_EN, treat op 10/11 as illegal: err pulses the cycle after start and no rA write occurs.

Structure
REQ-036 SHALL place op encodings, state encoding, WORD_W=31 and BYTE_W=6 in shared package mix_pkg.
REQ-037 SHALL instantiate exactly one sub-module, sm_adder, the 31-bit sign-magnitude add/subtract with carry out.

Verification
REQ-038 SHALL cover: ADD F=5, rA=+100, mem=+23, ack after 2 cycles -> ra_out=+123, no ovf_set, done 5 cycles after start.
REQ-039 SHALL cover: SUB F=5, rA=-5, mem=-5 -> ra_out=-0 (sign of rA), no ovf_set.
REQ-040 SHALL cover: ADD F=5, rA=+(2^30-1), mem=+1 -> ra_out=+0, ovf_set=1 together with ra_we.
REQ-041 SHALL cover: ADD F=9 (1:1), rA=+10, mem = sign -, byte1=3, other bytes 7 -> ra_out=+13.
REQ-042 SHALL cover: F=26 (3:2) -> err pulse, no mem_req, no ra_we; also mem_ack withheld for TIMEOUT cycles -> err, no ra_we.
REQ-043 SHALL cover: rst_n pulled low during FETCH, then mem_ack -> mem_req=0, no ra_we; with ADDSUB_INC_EN, DEC imm=+1, rA=+0 -> ra_out=-1 after 3 cycles.

Source files
------------

// File: rtl/mix_pkg.sv
// Shared MIX definitions: word geometry, op and state encodings, field helpers.
package mix_pkg;

    localparam int unsigned WORD_W = 31;
    localparam int unsigned BYTE_W = 6;
    localparam int unsigned MAG_W  = WORD_W - 1;
    localparam int unsigned NBYTES = 5;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_INC = 2'b10,
        OP_DEC = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_WRITE = 2'b11
    } state_e;

    // Sign-magnitude MIX word; sign=1 means negative.
    typedef struct packed {
        logic             sign;
        logic [MAG_W-1:0] mag;
    } word_t;

    function automatic logic fspec_ok(input logic [5:0] f);
        return (f[5:3] <= f[2:0]) && (f[2:0] <= 3'd5);
    endfunction

    // Bytes max(l,1)..r of a magnitude, right-justified; assumes r <= 5.
    function automatic logic [MAG_W-1:0] field_mag(input logic [MAG_W-1:0] mag,
                                                   input logic [2:0]       l,
                                                   input logic [2:0]       r);
        logic [2:0]       lp;
        int unsigned      nb;
        logic [MAG_W-1:0] mask;
        lp   = (l == 3'd0) ? 3'd1 : l;
        nb   = (r >= lp) ? (32'(r - lp) + 32'd1) : 32'd0;
        mask = {MAG_W{1'b1}} >> (BYTE_W * (NBYTES - nb));
        return (mag >> (BYTE_W * (NBYTES - 32'(r)))) & mask;
    endfunction

endpackage

// File: rtl/sm_adder.sv
// Combinational 31-bit sign-magnitude adder; zero results take the sign of i_a.
module sm_adder
    import mix_pkg::*;
(
    input  logic [WORD_W-1:0] i_a,
    input  logic [WORD_W-1:0] i_b,
    output logic [WORD_W-1:0] o_sum_c,
    output logic              o_carry_c
);

    word_t          w_a;
    word_t          w_b;
    word_t          w_s;
    logic [MAG_W:0] w_add;

    assign w_a   = i_a;
    assign w_b   = i_b;
    assign w_add = {1'b0, w_a.mag} + {1'b0, w_b.mag};

    always_comb begin
        w_s       = w_a;
        o_carry_c = 1'b0;
        if (w_a.sign == w_b.sign) begin
            w_s.mag   = w_add[MAG_W-1:0];
            o_carry_c = w_add[MAG_W];
        end else if (w_a.mag >= w_b.mag) begin
            w_s.mag = w_a.mag - w_b.mag;
        end else begin
            w_s.sign = w_b.sign;
            w_s.mag  = w_b.mag - w_a.mag;
        end
        if (w_s.mag == '0) begin
            w_s.sign = w_a.sign;
        end
    end

    assign o_sum_c = w_s;

endmodule

// File: rtl/addsub_ctl.sv
// MIX ADD/SUB (and optional INC/DEC) sequencer: fetch operand, field-extract, add, write rA.
// Optional feature: define ADDSUB_INC_EN to execute op 10/11 as INC/DEC with an immediate.
module addsub_ctl
    import mix_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [5:0]        fspec,
    input  logic [12:0]       imm,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_data,
    input  logic [WORD_W-1:0] ra_in,
    output logic [WORD_W-1:0] ra_out,
    output logic              ra_we,
    output logic              ovf_set,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            r_state,   w_state_nxt;
    logic              r_mem_req, w_mem_req_nxt;
    logic              r_ra_we,   w_ra_we_nxt;
    logic              r_ovf_set, w_ovf_set_nxt;
    logic              r_busy,    w_busy_nxt;
    logic              r_done,    w_done_nxt;
    logic              r_err,     w_err_nxt;
    logic [WORD_W-1:0] r_ra_out,  w_ra_out_nxt;
    logic [CNT_W-1:0]  r_cnt,     w_cnt_nxt;
    word_t             r_opnd,    w_opnd_nxt;
    logic              r_sub,     w_sub_nxt;
    logic [5:0]        r_fspec,   w_fspec_nxt;

    op_e               w_op;
    word_t             w_mem;
    logic [WORD_W-1:0] w_sum;
    logic              w_carry;

    assign w_op  = op_e'(op);
    assign w_mem = mem_data;

`ifndef ADDSUB_INC_EN
    logic w_unused_imm;
    assign w_unused_imm = ^imm;
`endif

    sm_adder u_adder (
        .i_a       (ra_in),
        .i_b       (r_opnd),
        .o_sum_c   (w_sum),
        .o_carry_c (w_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_mem_req <= 1'b0;
            r_ra_we   <= 1'b0;
            r_ovf_set <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_ra_out  <= '0;
            r_cnt     <= '0;
            r_opnd    <= '0;
            r_sub     <= 1'b0;
            r_fspec   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_mem_req <= w_mem_req_nxt;
            r_ra_we   <= w_ra_we_nxt;
            r_ovf_set <= w_ovf_set_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_ra_out  <= w_ra_out_nxt;
            r_cnt     <= w_cnt_nxt;
            r_opnd    <= w_opnd_nxt;
            r_sub     <= w_sub_nxt;
            r_fspec   <= w_fspec_nxt;
        end
    end

    // Outputs are computed for the next state so they line up with it after the edge.
    always_comb begin
        w_state_nxt   = r_state;
        w_mem_req_nxt = 1'b0;
        w_ra_we_nxt   = 1'b0;
        w_ovf_set_nxt = 1'b0;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        w_ra_out_nxt  = r_ra_out;
        w_cnt_nxt     = r_cnt;
        w_opnd_nxt    = r_opnd;
        w_sub_nxt     = r_sub;
        w_fspec_nxt   = r_fspec;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    case (w_op)
                        OP_ADD, OP_SUB: begin
                            if (fspec_ok(fspec)) begin
                                w_state_nxt   = ST_FETCH;
                                w_mem_req_nxt = 1'b1;
                                w_cnt_nxt     = '0;
                                w_sub_nxt     = (w_op == OP_SUB);
                                w_fspec_nxt   = fspec;
                            end else begin
                                w_err_nxt = 1'b1;
                            end
                        end
                        default: begin
`ifdef ADDSUB_INC_EN
                            w_opnd_nxt.sign = imm[12] ^ (w_op == OP_DEC);
                            w_opnd_nxt.mag  = MAG_W'(imm[11:0]);
                            w_state_nxt     = ST_EXEC;
`else
                            w_err_nxt = 1'b1;
`endif
                        end
                    endcase
                end
            end
            ST_FETCH: begin
                if (mem_ack) begin
                    w_opnd_nxt.sign = ((r_fspec[5:3] == 3'd0) ? w_mem.sign : 1'b0) ^ r_sub;
                    w_opnd_nxt.mag  = field_mag(w_mem.mag, r_fspec[5:3], r_fspec[2:0]);
                    w_state_nxt     = ST_EXEC;
                end else if (r_cnt == CNT_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt     = r_cnt + CNT_W'(1);
                    w_mem_req_nxt = 1'b1;
                end
            end
            ST_EXEC: begin
                w_ra_out_nxt  = w_sum;
                w_ovf_set_nxt = w_carry;
                w_ra_we_nxt   = 1'b1;
                w_done_nxt    = 1'b1;
                w_state_nxt   = ST_WRITE;
            end
            ST_WRITE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    assign mem_req = r_mem_req;
    assign ra_out  = r_ra_out;
    assign ra_we   = r_ra_we;
    assign ovf_set = r_ovf_set;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;

endmodule

// File: tb/tb_addsub_ctl.sv
// Bench for addsub_ctl: signed-integer reference model plus cycle-window expectations.
// Cycle n is the interval after the n-th rising edge; s is the edge that samples start.
module tb_addsub_ctl;

    localparam int TO = 255;
    localparam int K_NONE = 0, K_MEM = 1, K_TMO = 2, K_ERR = 3, K_INC = 4;

    typedef struct {
        int          kind;
        int          s;
        int          k;
        logic [30:0] res;
        logic        ovf;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic [5:0]  fspec = '0;
    logic [12:0] imm = '0;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [30:0] mem_data = '0;
    logic [30:0] ra_in = '0;
    logic [30:0] ra_out;
    logic        ra_we, ovf_set, busy, done, err;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    txn_t cur = '{K_NONE, 0, 0, 31'd0, 1'b0};

    addsub_ctl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .fspec(fspec), .imm(imm),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_data(mem_data), .ra_in(ra_in),
        .ra_out(ra_out), .ra_we(ra_we), .ovf_set(ovf_set), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint sval(input logic [30:0] w);
        longint m;
        m = longint'(w[29:0]);
        return w[30] ? -m : m;
    endfunction

    // Field value by base-64 digit arithmetic.
    function automatic longint fld(input logic [30:0] w, input int l, input int r);
        longint v, m, p;
        int lp;
        v  = 0;
        m  = longint'(w[29:0]);
        lp = (l == 0) ? 1 : l;
        for (int i = lp; i <= r; i++) begin
            p = 1;
            for (int j = 0; j < 5 - i; j++) p = p * 64;
            v = v * 64 + (m / p) % 64;
        end
        return v;
    endfunction

    // Returns {ovf, sign, magnitude} of the new rA.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [5:0] f,
                                          input logic [12:0] im, input logic [30:0] ra,
                                          input logic [30:0] md);
        longint opv, tot, a, m, lim;
        logic   ov, sg;
        lim = longint'(1) << 30;
        if (o < 2'd2) begin
            opv = fld(md, int'(f[5:3]), int'(f[2:0]));
            if (f[5:3] == 3'd0 && md[30]) opv = -opv;
        end else begin
            opv = longint'(im[11:0]);
            if (im[12]) opv = -opv;
        end
        if (o[0]) opv = -opv;
        tot = sval(ra) + opv;
        a   = (tot < 0) ? -tot : tot;
        ov  = (a >= lim);
        m   = a % lim;
        sg  = (m == 0) ? ra[30] : (tot < 0);
        return {ov, sg, 30'(m)};
    endfunction

    // Expected {mem_req, busy, done, err, ra_we, ovf_set} in cycle n.
    function automatic logic [5:0] exp_ctl(input txn_t t, input int n);
        logic rq, bz, dn, er;
        rq = 1'b0; bz = 1'b0; dn = 1'b0; er = 1'b0;
        case (t.kind)
            K_MEM: begin
                rq = (n >= t.s) && (n <= t.s + t.k - 1);
                bz = (n >= t.s) && (n <= t.s + t.k + 1);
                dn = (n == t.s + t.k + 1);
            end
            K_TMO: begin
                rq = (n >= t.s) && (n <= t.s + TO - 1);
                bz = rq;
                er = (n == t.s + TO);
            end
            K_ERR: er = (n == t.s);
            K_INC: begin
                bz = (n >= t.s) && (n <= t.s + 1);
                dn = (n == t.s + 1);
            end
            default: ;
        endcase
        return {rq, bz, dn, er, dn, dn & t.ovf};
    endfunction

    always @(negedge clk) begin : compare
        logic [5:0] e, a;
        e = rst_n ? exp_ctl(cur, cyc) : 6'b0;
        a = {mem_req, busy, done, err, ra_we, ovf_set};
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL ctl cyc=%0d {req,busy,done,err,we,ovf} got %b want %b", cyc, a, e);
        end
        if (e[1]) begin
            n_vec++;
            if (ra_out !== cur.res) begin
                n_bad++;
                $display("FAIL ra_out cyc=%0d got %h want %h", cyc, ra_out, cur.res);
            end
        end
        if (!rst_n) begin
            n_vec++;
            if (ra_out !== 31'd0) begin
                n_bad++;
                $display("FAIL ra_out_reset cyc=%0d got %h want 0", cyc, ra_out);
            end
        end
    end

    // k = mem_req cycles up to and including the ack cycle; k=0 withholds ack.
    task automatic run(input logic [1:0] o, input logic [5:0] f, input logic [12:0] im,
                       input logic [30:0] ra, input logic [30:0] md, input int k,
                       input bit pin, input logic [30:0] pres, input logic povf);
        logic [31:0] r;
        int          kind;
        if (o < 2'd2) begin
            if (f[5:3] > f[2:0] || f[2:0] > 3'd5) kind = K_ERR;
            else kind = (k == 0) ? K_TMO : K_MEM;
        end else begin
`ifdef ADDSUB_INC_EN
            kind = K_INC;
`else
            kind = K_ERR;
`endif
        end
        r = model(o, f, im, ra, md);
        @(posedge clk); #1;
        cur   = '{kind, cyc + 1, k, r[30:0], r[31]};
        start = 1'b1; op = o; fspec = f; imm = im; ra_in = ra;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); fspec = 6'($urandom); imm = 13'($urandom);
        if (kind == K_MEM || kind == K_TMO || kind == K_INC) begin
            start = 1'b1; op = 2'b00; fspec = 6'o05;
        end
        if (kind == K_MEM) begin
            for (int i = 1; i <= k; i++) begin
                if (i == k) begin mem_ack = 1'b1; mem_data = md; end
                else mem_data = 31'($urandom);
                @(posedge clk); #1;
                start = 1'b0; mem_ack = 1'b0; mem_data = 31'($urandom);
            end
            @(posedge clk); #1;
        end else if (kind == K_TMO) begin
            repeat (TO) begin
                @(posedge clk); #1;
                start = 1'b0;
            end
        end else if (kind == K_INC) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (pin && (kind == K_MEM || kind == K_INC)) begin
            @(negedge clk);
            n_vec++;
            if (ra_out !== pres || ovf_set !== povf || done !== 1'b1) begin
                n_bad++;
                $display("FAIL pin cyc=%0d ra_out=%h ovf=%b done=%b want ra_out=%h ovf=%b done=1",
                         cyc, ra_out, ovf_set, done, pres, povf);
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic reset_mid_fetch();
        @(posedge clk); #1;
        ra_in = 31'd77;
        cur   = '{K_MEM, cyc + 1, 1000, 31'd0, 1'b0};
        start = 1'b1; op = 2'b00; fspec = 6'o05;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        cur   = '{K_NONE, 0, 0, 31'd0, 1'b0};
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mem_ack = 1'b1; mem_data = 31'd5;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1);
    end

    initial begin : stim
        logic [30:0] md4;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);

        // ADD F=5, +100 + +23, ack in the 2nd mem_req cycle: done 5 cycles after start (inclusive).
        run(2'b00, 6'o05, 13'd0, {1'b0, 30'd100}, {1'b0, 30'd23}, 2, 1, {1'b0, 30'd123}, 1'b0);
        run(2'b01, 6'o05, 13'd0, {1'b1, 30'd5}, {1'b1, 30'd5}, 1, 1, {1'b1, 30'd0}, 1'b0);
        run(2'b00, 6'o05, 13'd0, {1'b0, 30'h3FFF_FFFF}, {1'b0, 30'd1}, 3, 1, {1'b0, 30'd0}, 1'b1);
        md4 = {1'b1, 6'd3, 6'd7, 6'd7, 6'd7, 6'd7};
        run(2'b00, 6'd9, 13'd0, {1'b0, 30'd10}, md4, 1, 1, {1'b0, 30'd13}, 1'b0);
        run(2'b00, 6'd26, 13'd0, {1'b0, 30'd10}, md4, 1, 0, '0, 1'b0);
        run(2'b01, 6'o06, 13'd0, {1'b0, 30'd10}, md4, 1, 0, '0, 1'b0);
        run(2'b00, 6'o05, 13'd0, {1'b0, 30'd10}, md4, 0, 0, '0, 1'b0);
        reset_mid_fetch();
        run(2'b11, 6'o00, {1'b0, 12'd1}, {1'b0, 30'd0}, '0, 1, 1, {1'b1, 30'd1}, 1'b0);
        run(2'b10, 6'o00, {1'b1, 12'd4095}, {1'b0, 30'd100}, '0, 1, 0, '0, 1'b0);

        for (int it = 0; it < 80; it++) begin
            logic [1:0]  o;
            logic [5:0]  f;
            logic [30:0] ra;
            int          l, r;
            o = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                f = 6'($urandom);
            end else begin
                l = $urandom_range(0, 5);
                r = $urandom_range(l, 5);
                f = {3'(l), 3'(r)};
            end
            ra = 31'($urandom);
            if ($urandom_range(0, 4) == 0) ra[29:24] = 6'h3F;
            run(o, f, 13'($urandom), ra, 31'($urandom), $urandom_range(1, 4), 0, '0, 1'b0);
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
